// File: rtl/alu_result_stage_pkg.sv
// Shared ALU opcode constants and result-stage state encoding.
package alu_result_stage_pkg;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_NOR = 4'b1100;
  localparam logic [3:0] OP_XOR = 4'b1101;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_e;

endpackage

// File: rtl/alu_result_stage_core.sv
// Combinational ALU: opcode select plus zero/overflow/illegal flags.
module alu_core
  import alu_result_stage_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [3:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] result_o,
  output logic             zero_o,
  output logic             ovf_o,
  output logic             illegal_o
);

  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;
  logic             lt;

  assign sum  = a_i + b_i;
  assign diff = a_i - b_i;
  // Signed compare directly, so SLT stays correct when a-b overflows.
  assign lt   = $signed(a_i) < $signed(b_i);

  always_comb begin
    result_o  = '0;
    ovf_o     = 1'b0;
    illegal_o = 1'b0;
    case (op_i)
      OP_AND: result_o = a_i & b_i;
      OP_OR:  result_o = a_i | b_i;
      OP_NOR: result_o = ~(a_i | b_i);
      OP_XOR: result_o = a_i ^ b_i;
      OP_ADD: begin
        result_o = sum;
        ovf_o    = (a_i[WIDTH-1] == b_i[WIDTH-1]) && (sum[WIDTH-1] != a_i[WIDTH-1]);
      end
      OP_SUB: begin
        result_o = diff;
        ovf_o    = (a_i[WIDTH-1] != b_i[WIDTH-1]) && (diff[WIDTH-1] != a_i[WIDTH-1]);
      end
      OP_SLT: result_o = {{(WIDTH-1){1'b0}}, lt};
      default: illegal_o = 1'b1;
    endcase
  end

  assign zero_o = (result_o == '0);

endmodule

// File: rtl/alu_result_stage.sv
// Execute-stage result register with a 2-entry skid buffer (output reg + skid reg).
//   state    | meaning
//   ST_EMPTY | no entry held, in_ready=1
//   ST_ONE   | output register valid, skid empty, in_ready=1
//   ST_FULL  | output and skid registers valid, in_ready=0
module alu_result_stage
  import alu_result_stage_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int RADDR = 5
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [RADDR-1:0] in_rd,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_zero,
  output logic             out_ovf,
  output logic             out_illegal,
  output logic [RADDR-1:0] out_rd
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] res_q, skid_res_q;
  logic             zero_q, skid_zero_q;
  logic             ovf_q, skid_ovf_q;
  logic             ill_q, skid_ill_q;
  logic [RADDR-1:0] rd_q, skid_rd_q;

  logic [WIDTH-1:0] core_res;
  logic             core_zero, core_ovf, core_ill;
  logic             accept, drain;
  logic             load_out, load_skid, move_skid;

  alu_core #(.WIDTH(WIDTH)) u_core (
    .op_i      (in_op),
    .a_i       (in_a),
    .b_i       (in_b),
    .result_o  (core_res),
    .zero_o    (core_zero),
    .ovf_o     (core_ovf),
    .illegal_o (core_ill)
  );

  assign in_ready  = (state_q != ST_FULL);
  assign out_valid = (state_q != ST_EMPTY);
  assign accept    = in_valid && in_ready;
  assign drain     = out_valid && out_ready;

  always_comb begin
    state_d   = state_q;
    load_out  = 1'b0;
    load_skid = 1'b0;
    move_skid = 1'b0;
    case (state_q)
      ST_EMPTY: if (accept) begin
        state_d  = ST_ONE;
        load_out = 1'b1;
      end
      ST_ONE: begin
        if (accept && !drain) begin
          state_d   = ST_FULL;
          load_skid = 1'b1;
        end else if (accept && drain) begin
          load_out = 1'b1;
        end else if (drain) begin
          state_d = ST_EMPTY;
        end
      end
      ST_FULL: if (drain) begin
        state_d   = ST_ONE;
        move_skid = 1'b1;
      end
      default: state_d = ST_EMPTY;
    endcase
    if (flush) state_d = ST_EMPTY;
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q     <= ST_EMPTY;
      res_q       <= '0;
      zero_q      <= 1'b0;
      ovf_q       <= 1'b0;
      ill_q       <= 1'b0;
      rd_q        <= '0;
      skid_res_q  <= '0;
      skid_zero_q <= 1'b0;
      skid_ovf_q  <= 1'b0;
      skid_ill_q  <= 1'b0;
      skid_rd_q   <= '0;
    end else begin
      state_q <= state_d;
      if (flush) begin
        res_q       <= '0;
        zero_q      <= 1'b0;
        ovf_q       <= 1'b0;
        ill_q       <= 1'b0;
        rd_q        <= '0;
        skid_res_q  <= '0;
        skid_zero_q <= 1'b0;
        skid_ovf_q  <= 1'b0;
        skid_ill_q  <= 1'b0;
        skid_rd_q   <= '0;
      end else begin
        if (load_out) begin
          res_q  <= core_res;
          zero_q <= core_zero;
          ovf_q  <= core_ovf;
          ill_q  <= core_ill;
          rd_q   <= in_rd;
        end
        if (move_skid) begin
          res_q       <= skid_res_q;
          zero_q      <= skid_zero_q;
          ovf_q       <= skid_ovf_q;
          ill_q       <= skid_ill_q;
          rd_q        <= skid_rd_q;
          skid_res_q  <= '0;
          skid_zero_q <= 1'b0;
          skid_ovf_q  <= 1'b0;
          skid_ill_q  <= 1'b0;
          skid_rd_q   <= '0;
        end
        if (load_skid) begin
          skid_res_q  <= core_res;
          skid_zero_q <= core_zero;
          skid_ovf_q  <= core_ovf;
          skid_ill_q  <= core_ill;
          skid_rd_q   <= in_rd;
        end
      end
    end
  end

  assign out_result  = res_q;
  assign out_zero    = zero_q;
  assign out_ovf     = ovf_q;
  assign out_illegal = ill_q;
  assign out_rd      = rd_q;

endmodule

// File: tb/tb_alu_result_stage.sv
// Randomized and directed bench for alu_result_stage against a queue-based reference model.
module tb_alu_result_stage;

  logic        Clk = 1'b0;
  logic        Rst = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  in_op = 4'd0;
  logic [31:0] in_a = 32'd0;
  logic [31:0] in_b = 32'd0;
  logic [4:0]  in_rd = 5'd0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_result;
  logic        out_zero, out_ovf, out_illegal;
  logic [4:0]  out_rd;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [31:0] res;
    logic        zero;
    logic        ovf;
    logic        ill;
    logic [4:0]  rd;
  } ent_t;

  ent_t q[$];

  alu_result_stage dut (
    .Clk(Clk), .Rst(Rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_a(in_a), .in_b(in_b), .in_rd(in_rd),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_zero(out_zero), .out_ovf(out_ovf),
    .out_illegal(out_illegal), .out_rd(out_rd)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic ent_t ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                   input logic [4:0] rd);
    ent_t   e;
    longint sa, sb, s;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    e.res = 32'd0; e.ovf = 1'b0; e.ill = 1'b0; e.rd = rd;
    case (op)
      4'b0000: e.res = a & b;
      4'b0001: e.res = a | b;
      4'b1100: e.res = ~(a | b);
      4'b1101: e.res = a ^ b;
      4'b0010: begin
        s = sa + sb;
        e.res = s[31:0];
        e.ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      4'b0110: begin
        s = sa - sb;
        e.res = s[31:0];
        e.ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      4'b0111: e.res = (sa < sb) ? 32'd1 : 32'd0;
      default: e.ill = 1'b1;
    endcase
    e.zero = (e.res == 32'd0);
    return e;
  endfunction

  task automatic check_all(input string tag);
    chk({tag, ".in_ready"}, 64'(in_ready), 64'(q.size() < 2));
    chk({tag, ".out_valid"}, 64'(out_valid), 64'(q.size() > 0));
    if (q.size() > 0) begin
      chk({tag, ".result"}, 64'(out_result), 64'(q[0].res));
      chk({tag, ".zero"}, 64'(out_zero), 64'(q[0].zero));
      chk({tag, ".ovf"}, 64'(out_ovf), 64'(q[0].ovf));
      chk({tag, ".illegal"}, 64'(out_illegal), 64'(q[0].ill));
      chk({tag, ".rd"}, 64'(out_rd), 64'(q[0].rd));
    end
  endtask

  // Drive inputs, take one clock edge, advance the model, check #1 later.
  task automatic cyc(input string tag, input logic v, input logic [3:0] op, input logic [31:0] a,
                     input logic [31:0] b, input logic [4:0] rd, input logic ordy, input logic fl);
    bit acc, drn;
    ent_t e;
    in_valid = v; in_op = op; in_a = a; in_b = b; in_rd = rd; out_ready = ordy; flush = fl;
    e = ref_alu(op, a, b, rd);
    acc = v && (q.size() < 2);
    drn = ordy && (q.size() > 0);
    @(posedge Clk);
    if (Rst || fl) q.delete();
    else begin
      if (drn) void'(q.pop_front());
      if (acc) q.push_back(e);
    end
    #1;
    check_all(tag);
  endtask

  initial begin
    // Reset: outputs and in_ready during reset, no transfer while Rst high
    #2;
    chk("rst.out_valid", 64'(out_valid), 64'd0);
    chk("rst.in_ready", 64'(in_ready), 64'd1);
    cyc("rst_hold", 1'b1, 4'b0010, 32'd1, 32'd2, 5'd1, 1'b1, 1'b0);
    chk("rst_hold.no_xfer", 64'(out_valid), 64'd0);
    #3 Rst = 1'b0;

    cyc("add_ovf", 1'b1, 4'b0010, 32'h7FFF_FFFF, 32'h1, 5'd3, 1'b1, 1'b0);
    chk("add_ovf.res", 64'(out_result), 64'h8000_0000);
    chk("add_ovf.flag", 64'(out_ovf), 64'd1);
    chk("add_ovf.rd", 64'(out_rd), 64'd3);
    cyc("sub_zero", 1'b1, 4'b0110, 32'd5, 32'd5, 5'd4, 1'b1, 1'b0);
    chk("sub_zero.zero", 64'(out_zero), 64'd1);
    cyc("slt", 1'b1, 4'b0111, 32'h8000_0000, 32'h1, 5'd5, 1'b1, 1'b0);
    chk("slt.res", 64'(out_result), 64'd1);
    cyc("nor", 1'b1, 4'b1100, 32'd0, 32'd0, 5'd6, 1'b1, 1'b0);
    chk("nor.res", 64'(out_result), 64'hFFFF_FFFF);
    cyc("illegal", 1'b1, 4'b1111, 32'd9, 32'd9, 5'd7, 1'b1, 1'b0);
    chk("illegal.flag", 64'(out_illegal), 64'd1);
    chk("illegal.res", 64'(out_result), 64'd0);
    cyc("drain", 1'b0, 4'd0, 32'd0, 32'd0, 5'd0, 1'b1, 1'b0);

    // Backpressure
    cyc("bp_and", 1'b1, 4'b0000, 32'hF0F0, 32'hFF00, 5'd8, 1'b0, 1'b0);
    cyc("bp_or", 1'b1, 4'b0001, 32'd1, 32'd2, 5'd9, 1'b0, 1'b0);
    chk("bp.held", 64'(out_result), 64'hF000);
    chk("bp.in_ready", 64'(in_ready), 64'd0);
    cyc("bp_stall", 1'b1, 4'b1101, 32'd7, 32'd7, 5'd10, 1'b0, 1'b0);
    chk("bp.still_held", 64'(out_result), 64'hF000);
    cyc("bp_rel", 1'b0, 4'd0, 32'd0, 32'd0, 5'd0, 1'b1, 1'b0);
    chk("bp_rel.res", 64'(out_result), 64'h3);
    chk("bp_rel.in_ready", 64'(in_ready), 64'd1);
    cyc("bp_empty", 1'b0, 4'd0, 32'd0, 32'd0, 5'd0, 1'b1, 1'b0);
    chk("bp_empty.no_dup", 64'(out_valid), 64'd0);

    // Streaming XOR
    for (int i = 0; i < 10; i++)
      cyc("stream", 1'b1, 4'b1101, $urandom, $urandom, 5'($urandom), 1'b1, 1'b0);
    cyc("stream_end", 1'b0, 4'd0, 32'd0, 32'd0, 5'd0, 1'b1, 1'b0);

    // Flush while FULL with a concurrent input
    cyc("fill0", 1'b1, 4'b0010, 32'd1, 32'd1, 5'd1, 1'b0, 1'b0);
    cyc("fill1", 1'b1, 4'b0010, 32'd2, 32'd2, 5'd2, 1'b0, 1'b0);
    cyc("flush", 1'b1, 4'b0010, 32'd3, 32'd3, 5'd3, 1'b1, 1'b1);
    chk("flush.out_valid", 64'(out_valid), 64'd0);
    chk("flush.in_ready", 64'(in_ready), 64'd1);
    cyc("post_flush", 1'b0, 4'd0, 32'd0, 32'd0, 5'd0, 1'b1, 1'b0);

    // Random traffic with occasional flushes and a mid-cycle reset
    for (int i = 0; i < 600; i++) begin
      logic [31:0] a, b;
      a = $urandom; b = $urandom;
      if ($urandom_range(0, 3) == 0) b = a;
      if ($urandom_range(0, 5) == 0) a = {1'b0, {31{1'b1}}};
      cyc("rand", 1'($urandom_range(0, 3) != 0), 4'($urandom), a, b, 5'($urandom),
          1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 31) == 0));
      if (i == 300) begin
        cyc("pre_rst", 1'b1, 4'b0001, 32'h55, 32'hAA, 5'd11, 1'b0, 1'b0);
        #2 Rst = 1'b1;
        #1;
        q.delete();
        chk("midrst.out_valid", 64'(out_valid), 64'd0);
        chk("midrst.result", 64'(out_result), 64'd0);
        chk("midrst.rd", 64'(out_rd), 64'd0);
        chk("midrst.in_ready", 64'(in_ready), 64'd1);
        cyc("in_rst", 1'b1, 4'b0010, 32'd4, 32'd4, 5'd4, 1'b1, 1'b0);
        #3 Rst = 1'b0;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
